// File: rtl/moving_average_filter_param.sv
`default_nettype none
// ============================================================================
// moving_average_filter_param : multi-channel recursive moving average (2^LOG2_N window)
// Revision 1.0
// ============================================================================
module moving_average_filter_param #(
   parameter int DATA_W = 16,
   parameter int LOG2_N = 3,
   parameter int NUM_CH = 1,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_primed
);

   localparam int N      = 1 << LOG2_N;
   localparam int ACC_W  = DATA_W + LOG2_N;
   localparam int FILL_W = LOG2_N + 1;
   localparam logic [CH_W:0]     NUM_CH_L = (CH_W+1)'(NUM_CH);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);

   logic signed [DATA_W-1:0] hist_q [NUM_CH][N];
   logic [LOG2_N-1:0]        ptr_q  [NUM_CH];
   logic signed [ACC_W-1:0]  acc_q  [NUM_CH];
   logic [FILL_W-1:0]        fill_q [NUM_CH];

   logic                     out_valid_q;
   logic [CH_W-1:0]          out_ch_q;
   logic signed [DATA_W-1:0] out_data_q;
   logic                     out_primed_q;

   logic                     ch_ok;
   logic                     accept;
   logic signed [DATA_W-1:0] old_sample;
   logic signed [ACC_W-1:0]  acc_cur;
   logic [FILL_W-1:0]        fill_cur;
   logic signed [ACC_W-1:0]  acc_d;
   logic [FILL_W-1:0]        fill_d;
   logic                     primed_d;

   assign ch_ok  = ({1'b0, in_ch} < NUM_CH_L);
   assign accept = in_valid && ch_ok && !clear && !reset;

   // Channel state is read straight from registers, so a back-to-back sample
   // on the same channel always sees the value written on the previous edge.
   always_comb begin
      old_sample = '0;
      acc_cur    = '0;
      fill_cur   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_ch == CH_W'(c)) begin
            old_sample = hist_q[c][ptr_q[c]];
            acc_cur    = acc_q[c];
            fill_cur   = fill_q[c];
         end
      end
   end

   always_comb begin
      acc_d    = acc_cur
               + {{LOG2_N{in_data[DATA_W-1]}}, in_data}
               - {{LOG2_N{old_sample[DATA_W-1]}}, old_sample};
      fill_d   = (fill_cur == FILL_MAX) ? fill_cur : fill_cur + 1'b1;
      primed_d = (fill_d == FILL_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ptr_q[c]  <= '0;
            acc_q[c]  <= '0;
            fill_q[c] <= '0;
            for (int e = 0; e < N; e++) begin
               hist_q[c][e] <= '0;
            end
         end
      end else if (accept) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
               hist_q[c][ptr_q[c]] <= in_data;
               ptr_q[c]            <= ptr_q[c] + 1'b1;
               acc_q[c]            <= acc_d;
               fill_q[c]           <= fill_d;
            end
         end
      end
   end

   // Upper DATA_W bits of the accumulator are the floor-divided mean.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_ch_q     <= '0;
         out_data_q   <= '0;
         out_primed_q <= 1'b0;
      end else begin
         out_valid_q <= accept;
         if (accept) begin
            out_ch_q     <= in_ch;
            out_data_q   <= acc_d[ACC_W-1:LOG2_N];
            out_primed_q <= primed_d;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;
   assign out_data   = out_data_q;
   assign out_primed = out_primed_q;

endmodule
`default_nettype wire

// File: tb/tb_moving_average_filter_param.sv
`default_nettype none
// ============================================================================
// tb_moving_average_filter_param : directed self-checking bench, N=8, 3 channels
// Revision 1.0
// ============================================================================
module tb_moving_average_filter_param;

   logic               clk = 1'b0;
   logic               reset;
   logic               clear;
   logic               in_valid;
   logic [1:0]         in_ch;
   logic signed [15:0] in_data;
   logic               out_valid;
   logic [1:0]         out_ch;
   logic signed [15:0] out_data;
   logic               out_primed;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   moving_average_filter_param #(
      .DATA_W (16),
      .LOG2_N (3),
      .NUM_CH (3)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ch      (in_ch),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .out_data   (out_data),
      .out_primed (out_primed)
   );

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic send(input int ch, input int d, input int exp_d, input int exp_pr,
                       input string tag);
      in_valid = 1'b1;
      in_ch    = 2'(ch);
      in_data  = 16'(d);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_val({tag, " valid"},  int'(out_valid), 1);
      check_val({tag, " ch"},     int'(out_ch), ch);
      check_val({tag, " data"},   int'(out_data), exp_d);
      check_val({tag, " primed"}, int'(out_primed), exp_pr);
   endtask

   task automatic flush(input bit use_reset, input int d, input string tag);
      in_valid = 1'b1;
      in_ch    = 2'd0;
      in_data  = 16'(d);
      if (use_reset) reset = 1'b1;
      else           clear = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset    = 1'b0;
      clear    = 1'b0;
      check_val({tag, " valid"}, int'(out_valid), 0);
      if (use_reset) begin
         check_val({tag, " data"},   int'(out_data), 0);
         check_val({tag, " ch"},     int'(out_ch), 0);
         check_val({tag, " primed"}, int'(out_primed), 0);
      end
   endtask

   initial begin
      int exp_v;
      int prev;
      reset    = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_ch    = '0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst valid",  int'(out_valid), 0);
      check_val("rst data",   int'(out_data), 0);
      check_val("rst ch",     int'(out_ch), 0);
      check_val("rst primed", int'(out_primed), 0);
      reset = 1'b0;

      // Step response: mean ramps by 100 per sample, primed on the 8th.
      for (int k = 1; k <= 8; k++)
         send(0, 800, 100 * k, (k == 8) ? 1 : 0, $sformatf("step%0d", k));
      send(0, 800, 800, 1, "step9");

      // Floor toward -inf and no drift once the -1 leaves the window.
      flush(1'b0, 0, "clr_a");
      send(0, -1, -1, 0, "floor1");
      for (int k = 2; k <= 16; k++)
         send(0, 0, (k <= 8) ? -1 : 0, (k >= 8) ? 1 : 0, $sformatf("floor%0d", k));

      // Full-scale extremes: no wrap on the way down.
      flush(1'b0, 0, "clr_b");
      for (int k = 1; k <= 8; k++)
         send(0, 32767, (32767 * k) >>> 3, (k == 8) ? 1 : 0, $sformatf("maxp%0d", k));
      prev = 32767;
      for (int k = 1; k <= 8; k++) begin
         exp_v = (32767 * (8 - k) - 32768 * k) >>> 3;
         send(0, -32768, exp_v, 1, $sformatf("maxn%0d", k));
         check_val($sformatf("maxn%0d mono", k), (int'(out_data) < prev) ? 1 : 0, 1);
         prev = int'(out_data);
      end
      check_val("maxn final", int'(out_data), -32768);

      // Two channels alternating every cycle, then same-channel bursts.
      flush(1'b0, 0, "clr_c");
      for (int k = 1; k <= 8; k++) begin
         send(0,  8000,  1000 * k, (k == 8) ? 1 : 0, $sformatf("il0_%0d", k));
         send(1, -8000, -1000 * k, (k == 8) ? 1 : 0, $sformatf("il1_%0d", k));
      end
      for (int k = 1; k <= 3; k++)
         send(1, -8000, -8000, 1, $sformatf("burst1_%0d", k));
      send(0, 0, 7000, 1, "burst0_1");
      send(0, 0, 6000, 1, "burst0_2");

      // Flush by clear: same-cycle sample dropped, every channel starts empty.
      flush(1'b0, 0, "clr_d");
      for (int k = 1; k <= 8; k++)
         send(0, 400, 50 * k, (k == 8) ? 1 : 0, $sformatf("prime_a%0d", k));
      flush(1'b0, 9999, "clr_mid");
      send(0, 800, 100, 0, "post_clr0");
      send(1, -8000, -1000, 0, "post_clr1");

      // Flush by reset.
      flush(1'b0, 0, "clr_e");
      for (int k = 1; k <= 8; k++)
         send(0, 400, 50 * k, (k == 8) ? 1 : 0, $sformatf("prime_b%0d", k));
      flush(1'b1, 9999, "rst_mid");
      send(0, 800, 100, 0, "post_rst0");

      // Idle gaps, held outputs and an out-of-range channel.
      flush(1'b0, 0, "clr_f");
      send(2, 80, 10, 0, "gap1");
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("idle%0d valid", k), int'(out_valid), 0);
         check_val($sformatf("idle%0d hold", k), int'(out_data), 10);
      end
      in_valid = 1'b1;
      in_ch    = 2'd3;
      in_data  = 16'sd9999;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_val("badch valid", int'(out_valid), 0);
      check_val("badch hold",  int'(out_ch), 2);
      send(2, 80, 20, 0, "gap2");
      send(0, 80, 10, 0, "gap_ch0");
      send(1, 80, 10, 0, "gap_ch1");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
